// File: rtl/aoc_pkg.sv
// Shared constants and types for the solver byte-stream transmit path.
// RESULT_ASCII_TX_CRLF_EN adds a CR state ahead of the LF terminator.
package aoc_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'd48;
   localparam logic [7:0] ASCII_LF   = 8'd10;
   localparam logic [7:0] ASCII_CR   = 8'd13;
   localparam logic [7:0] ASCII_DOT  = 8'd46;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SEND_DIG,
`ifdef RESULT_ASCII_TX_CRLF_EN
      SEND_CR,
`endif
      SEND_TERM
   } tx_state_t;

   // ceil(width * log10(2)) in fixed point
   function automatic int min_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: one shift per cycle, DATA_W cycles per value.
// done is asserted during the final shift; bcd_out then already shows the result.
module bin2bcd_iter #(
   parameter int DATA_W = 64,
   parameter int DIGITS = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd_out
);

   localparam int SR_W  = DIGITS * 4 + DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [SR_W-1:0]  sr_q, sr_d, adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      adj = sr_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[DATA_W+4*d +: 4] >= 4'd5)
            adj[DATA_W+4*d +: 4] = adj[DATA_W+4*d +: 4] + 4'd3;
      end
   end

   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done   = 1'b0;
      if (start) begin
         sr_d   = {{(DIGITS*4){1'b0}}, bin_in};
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         sr_d  = {adj[SR_W-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(DATA_W - 1)) begin
            busy_d = 1'b0;
            done   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign bcd_out = sr_d[SR_W-1 -: DIGITS*4];

endmodule

// File: rtl/result_ascii_tx.sv
// Prints a binary result as decimal ASCII plus terminator on a byte channel.
// Define RESULT_ASCII_TX_CRLF_EN for a CR LF terminator instead of LF.
module result_ascii_tx
   import aoc_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DIGITS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] result_in,
   input  logic              result_valid,
   output logic              result_ready,
   output logic [7:0]        char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              tx_done
);

   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
      $error("DIGITS too small for DATA_W");
   end

   tx_state_t          state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d, lead_ptr;
   logic               tx_done_q, tx_done_d;
   logic               conv_start, conv_busy, conv_done;
   logic [DIGITS*4-1:0] conv_bcd;
   logic [3:0]         digit;
   logic               rdy_c, cv_c;
   logic [7:0]         co_c;

   bin2bcd_iter #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk     (clk),
      .rst     (rst),
      .start   (conv_start),
      .bin_in  (result_in),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd_out (conv_bcd)
   );

   // Highest nonzero nibble; all-zero leaves 0 so a zero prints "0"
   always_comb begin
      lead_ptr = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (conv_bcd[4*i +: 4] != 4'd0)
            lead_ptr = PTR_W'(i);
      end
   end

   assign digit = conv_bcd[{ptr_q, 2'b00} +: 4];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tx_done_d  = 1'b0;
      conv_start = 1'b0;
      rdy_c      = 1'b0;
      cv_c       = 1'b0;
      co_c       = 8'h00;
      unique case (state_q)
         IDLE: begin
            rdy_c = !conv_busy;
            if (result_valid && rdy_c) begin
               conv_start = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               ptr_d   = lead_ptr;
               state_d = SEND_DIG;
            end
         end
         SEND_DIG: begin
            cv_c = 1'b1;
            co_c = ASCII_ZERO + {4'd0, digit};
            if (char_ready) begin
               if (ptr_q == '0)
`ifdef RESULT_ASCII_TX_CRLF_EN
                  state_d = SEND_CR;
`else
                  state_d = SEND_TERM;
`endif
               else
                  ptr_d = ptr_q - 1'b1;
            end
         end
`ifdef RESULT_ASCII_TX_CRLF_EN
         SEND_CR: begin
            cv_c = 1'b1;
            co_c = ASCII_CR;
            if (char_ready)
               state_d = SEND_TERM;
         end
`endif
         SEND_TERM: begin
            cv_c = 1'b1;
            co_c = ASCII_LF;
            if (char_ready) begin
               tx_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         tx_done_q <= tx_done_d;
      end
   end

   // Outputs forced idle while reset is held
   assign result_ready = rdy_c && !rst;
   assign char_valid   = cv_c && !rst;
   assign char_out     = rst ? 8'h00 : co_c;
   assign tx_done      = tx_done_q;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Scoreboard bench for result_ascii_tx: expected bytes queued at stimulus time.
// Build with RESULT_ASCII_TX_CRLF_EN to expect CR LF terminators.
module tb_result_ascii_tx;

   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] result_in = '0;
   logic              result_valid = 1'b0;
   logic              result_ready;
   logic [7:0]        char_out;
   logic              char_valid;
   logic              char_ready = 1'b0;
   logic              tx_done;

   int   n_err = 0;
   int   n_chk = 0;
   int   cyc = 0;
   int   c0 = 0;
   int   done_cnt = 0;
   int   nbytes = 0;
   bit   first_pending = 1'b0;
   bit   in_burst = 1'b0;
   bit   stall_pending = 1'b0;
   bit   rnd_mode = 1'b0;
   logic [7:0] prev_out = 8'h00;
   logic [7:0] exp_b;
   logic [7:0] exp_q[$];

   result_ascii_tx #(.DATA_W(DATA_W), .DIGITS(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .result_in    (result_in),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .char_out     (char_out),
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      char_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] v);
      logic [7:0]  d[$];
      logic [63:0] t;
      t = v;
      do begin
         d.push_front(8'(64'd48 + t % 64'd10));
         t = t / 64'd10;
      end while (t != 64'd0);
      foreach (d[i]) exp_q.push_back(d[i]);
`ifdef RESULT_ASCII_TX_CRLF_EN
      exp_q.push_back(8'd13);
`endif
      exp_q.push_back(8'd10);
   endtask

   task automatic send(input logic [63:0] v);
      bit got;
      got = 1'b0;
      push_exp(v);
      @(posedge clk);
      #1;
      result_in    = v;
      result_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (result_ready) begin
            got           = 1'b1;
            c0            = cyc;
            first_pending = 1'b1;
         end
      end
      check("accept", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      result_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (done_cnt >= target) ok = 1'b1;
      end
      check("done_seen", 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      check("done_count", 64'(done_cnt), 64'(target));
      check("drained", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_pending = 1'b0;
         in_burst      = 1'b0;
      end else begin
         if (stall_pending) begin
            check("stall_valid", 64'(char_valid), 64'd1);
            check("stall_data", 64'(char_out), 64'(prev_out));
         end
         if (in_burst && !rnd_mode)
            check("no_bubble", 64'(char_valid), 64'd1);
         if (char_valid && first_pending) begin
            check("first_latency", 64'(cyc - c0), 64'(DATA_W + 1));
            first_pending = 1'b0;
         end
         if (char_valid) in_burst = 1'b1;
         if (char_valid && char_ready) begin
            nbytes++;
            if (exp_q.size() == 0) begin
               check("byte_expected", 64'(exp_q.size()), 64'd1);
            end else begin
               exp_b = exp_q.pop_front();
               check("char", 64'(char_out), 64'(exp_b));
            end
            if (char_out == 8'd10) in_burst = 1'b0;
         end
         stall_pending = char_valid && !char_ready;
         prev_out      = char_out;
         if (tx_done) done_cnt++;
      end
   end

   initial begin
      int  viol;
      int  base;
      bit  ok;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(result_ready), 64'd0);
      check("rst_cvalid", 64'(char_valid), 64'd0);
      check("rst_cout", 64'(char_out), 64'd0);
      check("rst_done", 64'(tx_done), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(result_ready), 64'd1);

      send(64'd0);
      wait_done(1);
      send(64'd4361);
      wait_done(2);
      send(64'hFFFF_FFFF_FFFF_FFFF);
      wait_done(3);

      rnd_mode = 1'b1;
      send(64'd1000007);
      wait_done(4);
      rnd_mode = 1'b0;

      // second result held during conversion/send of 123
      send(64'd123);
      result_in    = 64'd99;
      result_valid = 1'b1;
      viol = 0;
      ok   = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (tx_done) ok = 1'b1;
         else if (result_ready) viol++;
      end
      check("busy_blocks_valid", 64'(viol), 64'd0);
      check("ovl_done_seen", 64'(ok), 64'd1);
      check("ready_with_done", 64'(result_ready), 64'd1);
      push_exp(64'd99);
      c0            = cyc;
      first_pending = 1'b1;
      @(posedge clk);
      #1;
      result_valid = 1'b0;
      wait_done(6);

      // reset in the middle of 55555
      base = nbytes;
      push_exp(64'd0);
      exp_q.delete();
      send(64'd55555);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (nbytes >= base + 2) ok = 1'b1;
      end
      check("two_digits_sent", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cvalid", 64'(char_valid), 64'd0);
      check("midrst_cout", 64'(char_out), 64'd0);
      check("midrst_ready", 64'(result_ready), 64'd0);
      check("midrst_done", 64'(tx_done), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      first_pending = 1'b0;
      @(negedge clk);
      check("ready_post_midrst", 64'(result_ready), 64'd1);
      send(64'd7);
      wait_done(7);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
